// File: rtl/receiver.sv
// UART receive path: 2-flop synchroniser, 16x oversampled deserialiser (5-8 data bits, 1/2 stop),
// first-word-fall-through RX FIFO, framing/overrun flags and line-held-low config request detect.
module receiver #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int CFG_REQ_CYCLES = CLK_FREQ_HZ / 100,
  parameter int RX_FIFO_DEPTH  = 64
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic       rx_fifo_read_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] stop_bits_number_i,
  output logic [7:0] data_rx_o,
  output logic       rx_done_o,
  output logic       rx_fifo_empty_o,
  output logic       rx_fifo_full_o,
  output logic       frame_error_o,
  output logic       overrun_error_o,
  output logic       config_req_slv_o,
  output logic [2:0] fsm_state_o
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int LW = $clog2(CFG_REQ_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    CFG_WAIT = 3'd4
  } state_t;

  state_t        state;
  logic          sync1, rx_s, rx_p;
  logic [LW-1:0] lc;
  logic [3:0]    cnt;
  logic [2:0]    bc;
  logic [7:0]    sr;
  logic          second_stop;

  logic [7:0]    mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]   count;

  logic          cfg_hit, stop_sample, last_stop, push_ok, fifo_wr, fifo_rd;
  logic          fifo_empty, fifo_full;
  logic [2:0]    nbits_m1;
  logic [7:0]    word;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_p  <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rx_s  <= sync1;
      rx_p  <= rx_s;
    end
  end

  // Low-cycle counter saturates so a line held low fires the request only once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lc <= '0;
    end else if (rx_s) begin
      lc <= '0;
    end else if (lc != LW'(CFG_REQ_CYCLES)) begin
      lc <= lc + 1'b1;
    end
  end

  assign cfg_hit     = !rx_s && (lc == LW'(CFG_REQ_CYCLES - 1));
  assign nbits_m1    = {1'b1, data_width_i};
  assign stop_sample = (state == STOP) && ov_baud_rt_i && (cnt == 4'd15);
  assign last_stop   = (stop_bits_number_i != 2'b01) || second_stop;
  assign push_ok     = stop_sample && rx_s && last_stop && !cfg_hit;
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == (AW+1)'(RX_FIFO_DEPTH));
  assign fifo_wr     = push_ok && !fifo_full;

  always_comb begin
    word = sr;
    case (data_width_i)
      2'b00:   word = sr >> 3;
      2'b01:   word = sr >> 2;
      2'b10:   word = sr >> 1;
      default: word = sr;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      bc               <= 3'd0;
      sr               <= 8'd0;
      second_stop      <= 1'b0;
      rx_done_o        <= 1'b0;
      frame_error_o    <= 1'b0;
      overrun_error_o  <= 1'b0;
      config_req_slv_o <= 1'b0;
    end else begin
      rx_done_o        <= fifo_wr;
      overrun_error_o  <= push_ok && fifo_full;
      frame_error_o    <= 1'b0;
      config_req_slv_o <= 1'b0;
      if (cfg_hit) begin
        config_req_slv_o <= 1'b1;
        state            <= CFG_WAIT;
        cnt              <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            if (!rx_s && rx_p) begin
              state       <= START;
              cnt         <= 4'd0;
              bc          <= 3'd0;
              second_stop <= 1'b0;
            end
          end
          START: begin
            if (ov_baud_rt_i) begin
              if (cnt == 4'd7) begin
                cnt   <= 4'd0;
                state <= rx_s ? IDLE : DATA;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          DATA: begin
            if (ov_baud_rt_i) begin
              cnt <= cnt + 4'd1;
              if (cnt == 4'd15) begin
                sr <= {rx_s, sr[7:1]};
                bc <= bc + 3'd1;
                if (bc == nbits_m1) state <= STOP;
              end
            end
          end
          STOP: begin
            if (ov_baud_rt_i) begin
              cnt <= cnt + 4'd1;
              if (cnt == 4'd15) begin
                if (!rx_s) begin
                  frame_error_o <= 1'b1;
                  state         <= IDLE;
                end else if (!last_stop) begin
                  second_stop <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
            end
          end
          CFG_WAIT: begin
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Read handshake: rx_fifo_read_i pops only while !rx_fifo_empty_o; data_rx_o is valid while !empty.
  assign fifo_rd = rx_fifo_read_i && !fifo_empty;
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge clk_i) begin
    if (fifo_wr) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_rx_o <= 8'd0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_nxt;
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (fifo_rd) begin
        if (count > (AW+1)'(1)) data_rx_o <= mem[rd_nxt];
        else if (fifo_wr)      data_rx_o <= word;
      end else if (fifo_wr && fifo_empty) begin
        data_rx_o <= word;
      end
    end
  end

  assign rx_fifo_empty_o = fifo_empty;
  assign rx_fifo_full_o  = fifo_full;
  assign fsm_state_o     = state;

endmodule
